// File: rtl/de_pipe_reg.sv
// Decode->execute pipeline register: resolves forwarded operands, latches D into E,
// inserts hazard bubbles, and tracks stall/flush counts and a sticky stall timeout.
module de_pipe_reg #(
    parameter int unsigned CTRL_W    = 16,
    parameter int unsigned MAX_STALL = 15,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              d_available,
    input  logic [1:0]        forward_d_q1,
    input  logic [1:0]        forward_d_q2,
    input  logic              d_valid,
    input  logic [31:0]       d_pc,
    input  logic [31:0]       d_qa_rf,
    input  logic [31:0]       d_qb_rf,
    input  logic [31:0]       e_aluout,
    input  logic [31:0]       m_aluout,
    input  logic [31:0]       m_memout,
    input  logic [31:0]       d_imm,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [4:0]        d_rn,
    input  logic              d_wreg,
    input  logic              d_m2reg,
    input  logic              d_setcond,
    input  logic [3:0]        d_jmp,
    output logic              e_valid,
    output logic [31:0]       e_pc,
    output logic [31:0]       e_qa,
    output logic [31:0]       e_qb,
    output logic [31:0]       e_imm,
    output logic [CTRL_W-1:0] e_ctrl,
    output logic [4:0]        e_rn,
    output logic              e_wreg,
    output logic              e_m2reg,
    output logic              e_setcond,
    output logic [3:0]        e_jmp,
    output logic              d_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_timeout
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] JMP_NEVER   = 4'h0;
    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    state_t      state, state_nxt;
    logic [7:0]  run_len, run_len_nxt;
    logic        timeout_nxt;
    logic        bubble;
    logic [31:0] qa, qb;

    always_comb begin
        unique case (forward_d_q1)
            2'b00:   qa = d_qa_rf;
            2'b01:   qa = e_aluout;
            2'b10:   qa = m_memout;
            default: qa = m_aluout;
        endcase
        unique case (forward_d_q2)
            2'b00:   qb = d_qb_rf;
            2'b01:   qb = e_aluout;
            2'b10:   qb = m_memout;
            default: qb = m_aluout;
        endcase
    end

    // A flushed instruction is discarded, so it never needs to wait for operands.
    assign bubble  = d_valid & ~d_available & ~flush;
    assign d_stall = hold | bubble;

    always_comb begin
        state_nxt   = state;
        run_len_nxt = run_len;
        timeout_nxt = stall_timeout;
        if (flush) begin
            state_nxt   = RUN;
            run_len_nxt = '0;
        end else if (bubble) begin
            state_nxt = STALL;
            if (state == RUN)
                run_len_nxt = 8'd1;
            else if (run_len != 8'hFF)
                run_len_nxt = run_len + 8'd1;
            if (run_len == STALL_LIMIT)
                timeout_nxt = 1'b1;
        end else begin
            state_nxt   = RUN;
            run_len_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            run_len       <= '0;
            stall_timeout <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            e_valid       <= 1'b0;
            e_pc          <= '0;
            e_qa          <= '0;
            e_qb          <= '0;
            e_imm         <= '0;
            e_ctrl        <= '0;
            e_rn          <= '0;
            e_wreg        <= 1'b0;
            e_m2reg       <= 1'b0;
            e_setcond     <= 1'b0;
            e_jmp         <= JMP_NEVER;
        end else if (!hold) begin
            state         <= state_nxt;
            run_len       <= run_len_nxt;
            stall_timeout <= timeout_nxt;
            if (flush || bubble) begin
                // Producer flags must drop so hazard_cu releases the stall next cycle.
                e_valid   <= 1'b0;
                e_pc      <= '0;
                e_qa      <= '0;
                e_qb      <= '0;
                e_imm     <= '0;
                e_ctrl    <= '0;
                e_rn      <= '0;
                e_wreg    <= 1'b0;
                e_m2reg   <= 1'b0;
                e_setcond <= 1'b0;
                e_jmp     <= JMP_NEVER;
                if (flush) begin
                    if (d_valid)
                        flush_cnt <= flush_cnt + 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                e_valid   <= d_valid;
                e_pc      <= d_pc;
                e_qa      <= qa;
                e_qb      <= qb;
                e_imm     <= d_imm;
                e_ctrl    <= d_ctrl;
                e_rn      <= d_rn;
                e_wreg    <= d_wreg & d_valid;
                e_m2reg   <= d_m2reg & d_valid;
                e_setcond <= d_setcond & d_valid;
                e_jmp     <= d_jmp;
            end
        end
    end

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: directed vectors push expectations, a negedge monitor checks them.
module tb_de_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, hold, flush, d_available, d_valid;
    logic [1:0]  forward_d_q1, forward_d_q2;
    logic [31:0] d_pc, d_qa_rf, d_qb_rf, e_aluout, m_aluout, m_memout, d_imm;
    logic [15:0] d_ctrl;
    logic [4:0]  d_rn;
    logic        d_wreg, d_m2reg, d_setcond;
    logic [3:0]  d_jmp;
    logic        e_valid, e_wreg, e_m2reg, e_setcond, d_stall, stall_timeout;
    logic [31:0] e_pc, e_qa, e_qb, e_imm, stall_cnt, flush_cnt;
    logic [15:0] e_ctrl;
    logic [4:0]  e_rn;
    logic [3:0]  e_jmp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        string       nm;
        logic        ev;
        logic [31:0] eqa, eqb, epc, scnt, fcnt;
        logic        tmo;
    } e_exp_t;

    typedef struct {
        string nm;
        logic  dst;
    } s_exp_t;

    e_exp_t e_q[$];
    s_exp_t s_q[$];

    always #5 clk = ~clk;

    de_pipe_reg #(.CTRL_W(16), .MAX_STALL(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .d_available(d_available),
        .forward_d_q1(forward_d_q1), .forward_d_q2(forward_d_q2), .d_valid(d_valid),
        .d_pc(d_pc), .d_qa_rf(d_qa_rf), .d_qb_rf(d_qb_rf), .e_aluout(e_aluout),
        .m_aluout(m_aluout), .m_memout(m_memout), .d_imm(d_imm), .d_ctrl(d_ctrl),
        .d_rn(d_rn), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_setcond(d_setcond),
        .d_jmp(d_jmp), .e_valid(e_valid), .e_pc(e_pc), .e_qa(e_qa), .e_qb(e_qb),
        .e_imm(e_imm), .e_ctrl(e_ctrl), .e_rn(e_rn), .e_wreg(e_wreg),
        .e_m2reg(e_m2reg), .e_setcond(e_setcond), .e_jmp(e_jmp), .d_stall(d_stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // All issued vectors carry a nonzero PC, so a zero expected PC marks a cleared E stage.
    always @(negedge clk) begin
        if (s_q.size() > 0) begin
            s_exp_t s;
            s = s_q.pop_front();
            chk(s.nm, "d_stall", {31'b0, d_stall}, {31'b0, s.dst});
        end
        if (e_q.size() > 0) begin
            e_exp_t e;
            logic   nz;
            e  = e_q.pop_front();
            nz = (e.epc != 32'h0);
            chk(e.nm, "e_valid",   {31'b0, e_valid},   {31'b0, e.ev});
            chk(e.nm, "e_wreg",    {31'b0, e_wreg},    {31'b0, e.ev});
            chk(e.nm, "e_m2reg",   {31'b0, e_m2reg},   {31'b0, e.ev});
            chk(e.nm, "e_setcond", {31'b0, e_setcond}, {31'b0, e.ev});
            chk(e.nm, "e_pc",      e_pc,               e.epc);
            chk(e.nm, "e_qa",      e_qa,               e.eqa);
            chk(e.nm, "e_qb",      e_qb,               e.eqb);
            chk(e.nm, "e_imm",     e_imm,              nz ? 32'h100 : 32'h0);
            chk(e.nm, "e_ctrl",    {16'b0, e_ctrl},    nz ? 32'h5A5A : 32'h0);
            chk(e.nm, "e_rn",      {27'b0, e_rn},      nz ? 32'd7 : 32'd0);
            chk(e.nm, "e_jmp",     {28'b0, e_jmp},     nz ? 32'd3 : 32'd0);
            chk(e.nm, "stall_cnt", stall_cnt,          e.scnt);
            chk(e.nm, "flush_cnt", flush_cnt,          e.fcnt);
            chk(e.nm, "timeout",   {31'b0, stall_timeout}, {31'b0, e.tmo});
        end
    end

    task automatic step(input string nm, input logic r, input logic h, input logic fl,
                        input logic dv, input logic da, input logic [1:0] f1, input logic [1:0] f2,
                        input logic [31:0] pc, input logic dst,
                        input logic ev, input logic [31:0] eqa, input logic [31:0] eqb,
                        input logic [31:0] epc, input logic [31:0] sc, input logic [31:0] fc,
                        input logic tmo);
        e_exp_t e;
        s_exp_t s;
        rst = r; hold = h; flush = fl; d_valid = dv; d_available = da;
        forward_d_q1 = f1; forward_d_q2 = f2; d_pc = pc;
        s.nm = nm; s.dst = dst;
        s_q.push_back(s);
        @(posedge clk);
        #1;
        e.nm = nm; e.ev = ev; e.eqa = eqa; e.eqb = eqb; e.epc = epc;
        e.scnt = sc; e.fcnt = fc; e.tmo = tmo;
        e_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; d_available = 1'b1; d_valid = 1'b0;
        forward_d_q1 = 2'b00; forward_d_q2 = 2'b00; d_pc = '0;
        d_qa_rf = 32'h11; d_qb_rf = 32'h22;
        e_aluout = 32'hA; m_aluout = 32'hB; m_memout = 32'hC; d_imm = 32'h100;
        d_ctrl = 16'h5A5A; d_rn = 5'd7; d_wreg = 1'b1; d_m2reg = 1'b1; d_setcond = 1'b1;
        d_jmp = 4'd3;
        @(posedge clk);
        #1;
        //    name        rst h fl dv da  f1     f2     pc          dst  ev qa     qb     epc         scnt fcnt tmo
        step("reset",     1, 0, 0, 0, 1, 2'b00, 2'b00, 32'h0,     0,   0, 32'h0, 32'h0, 32'h0,     0,   0,   0);
        step("issue",     0, 0, 0, 1, 1, 2'b00, 2'b00, 32'h1000,  0,   1, 32'h11, 32'h22, 32'h1000, 0,  0,   0);
        step("fwd_e_m",   0, 0, 0, 1, 1, 2'b01, 2'b11, 32'h1004,  0,   1, 32'hA, 32'hB, 32'h1004,  0,   0,   0);
        step("fwd_mem",   0, 0, 0, 1, 1, 2'b10, 2'b00, 32'h1008,  0,   1, 32'hC, 32'h22, 32'h1008, 0,   0,   0);
        step("load_use",  0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h100C,  1,   0, 32'h0, 32'h0, 32'h0,     1,   0,   0);
        step("reissue",   0, 0, 0, 1, 1, 2'b00, 2'b00, 32'h100C,  0,   1, 32'h11, 32'h22, 32'h100C, 1,  0,   0);
        step("flush_stl", 0, 0, 1, 1, 0, 2'b00, 2'b00, 32'h1010,  0,   0, 32'h0, 32'h0, 32'h0,     1,   1,   0);
        step("stall_1",   0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     2,   1,   0);
        step("hold_1",    0, 1, 0, 1, 0, 2'b01, 2'b01, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     2,   1,   0);
        step("hold_2",    0, 1, 0, 1, 0, 2'b01, 2'b01, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     2,   1,   0);
        step("hold_3",    0, 1, 1, 1, 1, 2'b01, 2'b01, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     2,   1,   0);
        step("stall_2",   0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     3,   1,   0);
        step("stall_3",   0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     4,   1,   0);
        step("stall_4",   0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1014,  1,   0, 32'h0, 32'h0, 32'h0,     5,   1,   1);
        step("recover",   0, 0, 0, 1, 1, 2'b00, 2'b00, 32'h1018,  0,   1, 32'h11, 32'h22, 32'h1018, 5,  1,   1);
        step("no_valid",  0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h101C,  0,   0, 32'h11, 32'h22, 32'h101C, 5,  1,   1);
        step("flush_nv",  0, 0, 1, 0, 1, 2'b00, 2'b00, 32'h1020,  0,   0, 32'h0, 32'h0, 32'h0,     5,   1,   1);
        step("stall_5",   0, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1024,  1,   0, 32'h0, 32'h0, 32'h0,     6,   1,   1);
        step("rst_mid",   1, 0, 0, 1, 0, 2'b00, 2'b00, 32'h1024,  1,   0, 32'h0, 32'h0, 32'h0,     0,   0,   0);
        step("post_rst",  0, 0, 0, 1, 1, 2'b01, 2'b10, 32'h2000,  0,   1, 32'hA, 32'hC, 32'h2000,  0,   0,   0);
        for (int i = 0; i < 4 && (e_q.size() > 0 || s_q.size() > 0); i++) @(negedge clk);
        #1;
        if (e_q.size() > 0 || s_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", e_q.size() + s_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
